// File: rtl/fnd_4digit_scan_cntr_if.sv
// rtl/fnd_4digit_scan_cntr_if.sv - display word input and scanned segment/digit output bundle
//
// Purpose: groups the word/strobe/dp inputs and the scanned display outputs of
// fnd_4digit_scan_cntr.
// Signals:
//   value[15:0]   four nibbles, value[3:0] is digit 0 (rightmost)
//   value_valid   one-cycle strobe capturing value into the pending register
//   dp_en[3:0]    per-digit decimal point enable, active-high, sampled live
//   seg_7[7:0]    {a,b,c,d,e,f,g,p} segments, active-low
//   com[3:0]      digit enables, active-low
//   frame_done    one-cycle pulse after each full 4-digit frame
// Modports: master = word source / display side, slave = scan controller.

interface fnd_4digit_scan_cntr_if;
    logic [15:0] value;
    logic        value_valid;
    logic [3:0]  dp_en;
    logic [7:0]  seg_7;
    logic [3:0]  com;
    logic        frame_done;

    modport master (
        output value,
        output value_valid,
        output dp_en,
        input  seg_7,
        input  com,
        input  frame_done
    );

    modport slave (
        input  value,
        input  value_valid,
        input  dp_en,
        output seg_7,
        output com,
        output frame_done
    );
endinterface

// File: rtl/fnd_4digit_scan_cntr.sv
// rtl/fnd_4digit_scan_cntr.sv - tear-free 4-digit common-anode 7-segment scan driver
//
// Purpose: latches 16-bit display words, swaps them onto the display only at
// frame boundaries, scans one digit per SCAN_DIV-cycle slot with DEAD_CYCLES
// of blanking at the start of each slot, and decodes nibbles to active-low
// abcdefgp patterns. All outputs are registered (one cycle behind cnt/idx).
// Ports:
//   clk       rising-edge system clock
//   reset_p   synchronous active-high reset
//   bus       fnd_4digit_scan_cntr_if.slave (value, value_valid, dp_en in;
//             seg_7, com, frame_done out)
// Parameters: SCAN_DIV (cycles per slot, >= 2), DEAD_CYCLES (< SCAN_DIV).
// Optional macro: LEADING_ZERO_BLANK_EN blanks the segments of leading-zero
// digits 3..1 (com and dp still driven).

module fnd_4digit_scan_cntr #(
    parameter int SCAN_DIV    = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   reset_p,
    fnd_4digit_scan_cntr_if.slave  bus
);

    localparam int             CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_DIV - 1);
    // One extra bit so the dead-time limit compares cleanly even at DEAD_CYCLES=0.
    localparam logic [CW:0]    DEAD_LIM = (CW + 1)'(DEAD_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_flag_q, pend_flag_d;
    logic [15:0]   disp_q, disp_d;
    logic [7:0]    seg_7_q, seg_7_d;
    logic [3:0]    com_q, com_d;
    logic          frame_done_q, frame_done_d;

    logic          slot_last;
    logic          frame_last;
    logic [3:0]    nib;
    logic [6:0]    seg_body;
    logic          lead_blank;

    // Active-low abcdefg for one hex nibble.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001101;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0001100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        pend_d       = pend_q;
        pend_flag_d  = pend_flag_q;
        disp_d       = disp_q;
        seg_7_d      = 8'hFF;
        com_d        = 4'b1111;
        frame_done_d = 1'b0;
        lead_blank   = 1'b0;

        slot_last  = (cnt_q == CNT_LAST);
        frame_last = slot_last && (idx_q == 2'd3);

        if (slot_last) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Swap happens with the pend value from before this edge; a strobe on
        // the same edge is applied afterwards so it stays pending for the next frame.
        if (frame_last && pend_flag_q) begin
            disp_d      = pend_q;
            pend_flag_d = 1'b0;
        end
        if (bus.value_valid) begin
            pend_d      = bus.value;
            pend_flag_d = 1'b1;
        end

        frame_done_d = frame_last;

        nib      = 4'(disp_q >> {idx_q, 2'b00});
        seg_body = decode(nib);

`ifdef LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd3:    lead_blank = (disp_q[15:12] == 4'h0);
            2'd2:    lead_blank = (disp_q[15:8] == 8'h00);
            2'd1:    lead_blank = (disp_q[15:4] == 12'h000);
            default: lead_blank = 1'b0;
        endcase
`else
        lead_blank = 1'b0;
`endif
        if (lead_blank) begin
            seg_body = 7'h7F;
        end

        if ({1'b0, cnt_q} >= DEAD_LIM) begin
            com_d   = ~(4'b0001 << idx_q);
            seg_7_d = {seg_body, ~bus.dp_en[idx_q]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            pend_q       <= 16'h0000;
            pend_flag_q  <= 1'b0;
            disp_q       <= 16'h0000;
            seg_7_q      <= 8'hFF;
            com_q        <= 4'b1111;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_flag_q  <= pend_flag_d;
            disp_q       <= disp_d;
            seg_7_q      <= seg_7_d;
            com_q        <= com_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg_7      = seg_7_q;
    assign bus.com        = com_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: doc/fnd_4digit_scan_cntr.md
Name: fnd_4digit_scan_cntr

Overview:
- Time-multiplexed driver for a 4-digit common-anode 7-segment display. It consumes the 16-bit BCD/hex word produced by the binary-to-BCD stage.
- Latches each new word and swaps it onto the display only at frame boundaries, so no frame ever shows a mix of old and new digits.
- Scans one digit per slot and inserts dead time between digits to suppress ghosting.
- Decodes each nibble internally to active-low abcdefgp segment patterns.

Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot. Must be >= 2.
- DEAD_CYCLES, 1000: blank cycles at the start of each slot. Must satisfy 0 <= DEAD_CYCLES < SCAN_DIV.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset_p  input  1  synchronous, active-high reset.
- value  input  16  four nibbles. value[3:0] is the rightmost digit (digit 0).
- value_valid  input  1  one-cycle strobe that captures value into the pending register.
- dp_en  input  4  decimal-point enable per digit, active-high, sampled live.
- seg_7  output  8  segments {a,b,c,d,e,f,g,p}, active-low; seg_7[0] is the dp.
- com  output  4  digit enables, active-low; com[i] selects digit i.
- frame_done  output  1  one-cycle pulse at the end of each full 4-digit frame.

Behaviour:
- One clock domain. Reset is synchronous and active-high on reset_p; the clock is clk.
- Reset state:
  - Outputs: seg_7=8'hFF, com=4'b1111, frame_done=0.
  - Internals: cnt=0, idx=0, pend=0, pend_flag=0, disp=0.
  - value_valid is ignored while reset_p=1.
- Reset asserted mid-frame:
  - Outputs read blank on the first cycle after the reset edge.
  - The displayed word and any pending word are discarded.
- Slot counter:
  - cnt counts 0..SCAN_DIV-1, then wraps to 0 and increments idx.
  - idx wraps 3->0.
  - Frame period is 4*SCAN_DIV cycles.
- Slot phases, decoded from (idx, cnt):
  - DEAD (cnt < DEAD_CYCLES): com=4'b1111, seg_7=8'hFF.
  - DRIVE (otherwise): com=~(4'b0001<<idx), seg_7[7:1]=decode(disp nibble idx), seg_7[0]=~dp_en[idx].
- Output timing: seg_7, com and frame_done are registered. The value seen in cycle n reflects cnt/idx of cycle n-1 (1-cycle latency). No combinational path from any input to any output.
- Decode table, active-low abcdefg+p with p shown as 1:
  - 0=0000_0011, 1=1001_1111, 2=0010_0101, 3=0000_1101
  - 4=1001_1001, 5=0100_1001, 6=0100_0001, 7=0001_1011
  - 8=0000_0001, 9=0001_1001, A=0001_0001, b=1100_0001
  - C=0110_0011, d=1000_0101, E=0110_0001, F=0111_0001
- Capture: when value_valid=1, pend<=value and pend_flag<=1. Multiple strobes in one frame: the last one wins.
- Frame boundary (edge where idx=3 and cnt=SCAN_DIV-1):
  - If pend_flag=1 before this edge: disp<=pend and pend_flag<=0.
  - frame_done=1 for the following cycle only.
- Strobe on the frame-boundary edge itself:
  - Transfer uses the pend contents from before the edge.
  - The new value lands in pend with pend_flag=1 and is displayed in the frame after next.
- First frame after reset shows disp=0, i.e. "0000".
- DEAD_CYCLES=0: no blank slot; digits switch back-to-back.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - During DRIVE, digit i (i=3..1) has seg_7[7:1]=7'h7F when nibble i and all higher nibbles of disp are zero.
  - For such a digit, com is still driven and dp still follows dp_en.
  - Digit 0 is never blanked.
- Undefined: all four digits are always decoded.

Test Plan:
All scenarios use SCAN_DIV=8, DEAD_CYCLES=2.
- Reset: hold reset_p for 3 cycles with value_valid=1 -> seg_7=8'hFF, com=4'b1111, frame_done=0 throughout; the first frame afterwards shows "0000".
- Scan order:
  - Stimulus: strobe value=16'h1234 in frame 0.
  - Frame 0: shows 0.
  - Frame 1: slot sequence com 1110/1101/1011/0111 with seg 1001_1001, 0000_1101, 0010_0101, 1001_1111.
  - Each slot: 2 blank cycles then 6 drive cycles.
  - frame_done pulses every 32 cycles.
- No tearing: with 16'h1234 displayed, strobe 16'h00AB then 16'hABCD while idx=2 -> the current frame stays "1234" on every digit; the next frame shows "ABCD"; 00AB never appears.
- Boundary collision: strobe 16'h5555 in frame k, then 16'h9999 exactly on the boundary edge -> frame k+1 shows 5555, frame k+2 shows 9999.
- Mid-frame reset: pulse reset_p during idx=2 DRIVE -> next cycle com=1111, seg=FF; the scan restarts at idx=0 showing "0000".
- Leading-zero blanking:
  - Stimulus: value=16'h0050, dp_en=4'b0100.
  - With LEADING_ZERO_BLANK_EN: digit3 seg=8'hFF; digit2 seg=8'hFE (blank segments, dp lit); digit1 shows "5"; digit0 shows "0".
  - Without the macro: digit3 shows "0", digit2 shows "0"+dp, then "5", "0".
